// File: rtl/ebus_responder_if.sv
// ebus_responder_if -- EBUS handshake and data bundle between the EBOX side
// (master) and an I/O device responder (slave).
//
// Signals:
//   ebusDS      [0:6]   device select code from the EBOX
//   ebusFunc    [2:0]   function code: 0 CONO, 1 CONI, 2 DATAO, 3 DATAI, 4 PI-serve
//   ebusDemand          EBOX demand, four-phase request
//   ebusDataIn  [0:35]  muxed EBUS data seen by the responder
//   ebusXfer            responder transfer acknowledge
//   ebusDriving         responder requests the EBUS data mux
//   ebusDataOut [0:35]  responder data onto the bus, zero when not driving
//   ebusPI      [1:7]   priority-interrupt request lines

interface ebus_responder_if;
    logic [0:6]  ebusDS;
    logic [2:0]  ebusFunc;
    logic        ebusDemand;
    logic [0:35] ebusDataIn;
    logic        ebusXfer;
    logic        ebusDriving;
    logic [0:35] ebusDataOut;
    logic [1:7]  ebusPI;

    modport master (
        output ebusDS,
        output ebusFunc,
        output ebusDemand,
        output ebusDataIn,
        input  ebusXfer,
        input  ebusDriving,
        input  ebusDataOut,
        input  ebusPI
    );

    modport slave (
        input  ebusDS,
        input  ebusFunc,
        input  ebusDemand,
        input  ebusDataIn,
        output ebusXfer,
        output ebusDriving,
        output ebusDataOut,
        output ebusPI
    );
endinterface

// File: rtl/ebus_responder.sv
// ebus_responder -- EBUS I/O device responder.
//
// Answers CONO / CONI / DATAO / DATAI demands addressed to DEV_NUM with a
// programmable response delay, latches write data for the device, snapshots
// device read data onto the bus, and raises one PI request line selected by
// the 3-bit PI assignment (PIA) written by CONO.
//
// Optional feature: define EBUS_PI_VECTOR_EN to enable PI-serve (function 4),
// which answers with the VECTOR parameter when the EBOX serves the level this
// device is requesting on. Without the macro function 4 is ignored.
//
// Ports:
//   clk          single clock, rising edge
//   CROBAR       synchronous active-high reset
//   ebus         ebus_responder_if.slave (select, function, demand, data in,
//                xfer, driving, data out, PI lines)
//   coniIn       [0:32] device status returned by CONI
//   dataiIn      [0:35] device data returned by DATAI
//   devIntReq    device interrupt request level
//   conoOut      [0:35] data latched by CONO
//   dataoOut     [0:35] data latched by DATAO
//   conoStrobe   one-cycle pulse when conoOut is loaded
//   dataoStrobe  one-cycle pulse when dataoOut is loaded
//   dataiAck     one-cycle pulse when dataiIn is snapshotted

module ebus_responder #(
    parameter logic [0:6]  DEV_NUM    = 7'o40,
    parameter int unsigned RESP_DELAY = 2
`ifdef EBUS_PI_VECTOR_EN
    ,
    parameter logic [0:35] VECTOR     = 36'o0
`endif
) (
    input  logic                   clk,
    input  logic                   CROBAR,
    ebus_responder_if.slave        ebus,
    input  logic [0:32]            coniIn,
    input  logic [0:35]            dataiIn,
    input  logic                   devIntReq,
    output logic [0:35]            conoOut,
    output logic [0:35]            dataoOut,
    output logic                   conoStrobe,
    output logic                   dataoStrobe,
    output logic                   dataiAck
);

    localparam logic [2:0] FN_CONO    = 3'd0;
    localparam logic [2:0] FN_CONI    = 3'd1;
    localparam logic [2:0] FN_DATAO   = 3'd2;
    localparam logic [2:0] FN_DATAI   = 3'd3;
`ifdef EBUS_PI_VECTOR_EN
    localparam logic [2:0] FN_PISERVE = 3'd4;
`endif

    localparam logic [3:0] DELAY_INIT = 4'(RESP_DELAY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_REL
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [2:0]  func_q, func_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  pia_q, pia_d;
    logic        xfer_q, xfer_d;
    logic        driving_q, driving_d;
    logic [0:35] data_out_q, data_out_d;
    logic [1:7]  pi_q, pi_d;
    logic [0:35] cono_q, cono_d;
    logic [0:35] datao_q, datao_d;
    logic        cono_stb_q, cono_stb_d;
    logic        datao_stb_q, datao_stb_d;
    logic        datai_ack_q, datai_ack_d;

    logic        sel_std;
    logic        sel_pi;
    logic        select_hit;

    // One request line per PI level; level 0 means "no interrupts assigned".
    function automatic logic [1:7] pi_lines(input logic [2:0] pia, input logic req);
        logic [1:7] lines;
        for (int i = 1; i <= 7; i++) begin
            lines[i] = req && (pia == 3'(i));
        end
        return lines;
    endfunction

    // Does the current bus cycle address this device with a function we serve?
    always_comb begin
        sel_std = (ebus.ebusDS == DEV_NUM) && (ebus.ebusFunc <= FN_DATAI);
`ifdef EBUS_PI_VECTOR_EN
        // PI-serve addresses by level only: ebusDS[4:6] carries the level being
        // served and must match the level this device is requesting on.
        sel_pi = (ebus.ebusFunc == FN_PISERVE) && devIntReq &&
                 (pia_q != 3'd0) && (ebus.ebusDS[4:6] == pia_q);
`else
        sel_pi = 1'b0;
`endif
        select_hit = ebus.ebusDemand && (sel_std || sel_pi);
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        func_d      = func_q;
        cnt_d       = cnt_q;
        pia_d       = pia_q;
        xfer_d      = xfer_q;
        driving_d   = driving_q;
        data_out_d  = data_out_q;
        cono_d      = cono_q;
        datao_d     = datao_q;
        cono_stb_d  = 1'b0;
        datao_stb_d = 1'b0;
        datai_ack_d = 1'b0;
        // PI lines lag PIA by one register stage, so a CONO that moves the
        // level swaps old and new lines on a single edge.
        pi_d        = pi_lines(pia_q, devIntReq);

        case (state_q)
            ST_IDLE: begin
                // A demand that is still high after a previous cycle (or
                // reset) must be seen low once before we answer again.
                if (!ebus.ebusDemand) begin
                    armed_d = 1'b1;
                end else if (armed_q && select_hit) begin
                    func_d  = ebus.ebusFunc;
                    cnt_d   = DELAY_INIT;
                    armed_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!ebus.ebusDemand) begin
                    // EBOX gave up before we answered: silent return to idle.
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_XFER;
                    xfer_d  = 1'b1;
                    case (func_q)
                        FN_CONO: begin
                            cono_d     = ebus.ebusDataIn;
                            cono_stb_d = 1'b1;
                            pia_d      = ebus.ebusDataIn[33:35];
                        end
                        FN_DATAO: begin
                            datao_d     = ebus.ebusDataIn;
                            datao_stb_d = 1'b1;
                        end
                        FN_CONI: begin
                            data_out_d = {coniIn, pia_q};
                            driving_d  = 1'b1;
                        end
                        FN_DATAI: begin
                            data_out_d  = dataiIn;
                            driving_d   = 1'b1;
                            datai_ack_d = 1'b1;
                        end
`ifdef EBUS_PI_VECTOR_EN
                        FN_PISERVE: begin
                            data_out_d = VECTOR;
                            driving_d  = 1'b1;
                        end
`endif
                        default: begin
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_XFER: begin
                // Read data stays frozen at the entry snapshot until release.
                if (!ebus.ebusDemand) begin
                    xfer_d     = 1'b0;
                    driving_d  = 1'b0;
                    data_out_d = '0;
                    state_d    = ST_REL;
                end
            end

            ST_REL: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            func_q      <= 3'd0;
            cnt_q       <= 4'd0;
            pia_q       <= 3'd0;
            xfer_q      <= 1'b0;
            driving_q   <= 1'b0;
            data_out_q  <= '0;
            pi_q        <= '0;
            cono_q      <= '0;
            datao_q     <= '0;
            cono_stb_q  <= 1'b0;
            datao_stb_q <= 1'b0;
            datai_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            func_q      <= func_d;
            cnt_q       <= cnt_d;
            pia_q       <= pia_d;
            xfer_q      <= xfer_d;
            driving_q   <= driving_d;
            data_out_q  <= data_out_d;
            pi_q        <= pi_d;
            cono_q      <= cono_d;
            datao_q     <= datao_d;
            cono_stb_q  <= cono_stb_d;
            datao_stb_q <= datao_stb_d;
            datai_ack_q <= datai_ack_d;
        end
    end

    assign ebus.ebusXfer    = xfer_q;
    assign ebus.ebusDriving = driving_q;
    assign ebus.ebusDataOut = data_out_q;
    assign ebus.ebusPI      = pi_q;
    assign conoOut          = cono_q;
    assign dataoOut         = datao_q;
    assign conoStrobe       = cono_stb_q;
    assign dataoStrobe      = datao_stb_q;
    assign dataiAck         = datai_ack_q;

endmodule

// File: tb/tb_ebus_responder.sv
// tb_ebus_responder -- self-checking bench for ebus_responder.
// Transactions are generated with $urandom and predicted by a transaction-level
// model (selection rule, response latency, expected bus data, PI level).

module tb_ebus_responder;

    localparam int         RD  = 2;
    localparam logic [0:6] DEV = 7'o40;
`ifdef EBUS_PI_VECTOR_EN
    localparam logic [0:35] VEC = 36'o123;
`endif

    logic        clk = 1'b0;
    logic        CROBAR;
    logic [0:32] coniIn;
    logic [0:35] dataiIn;
    logic        devIntReq;
    logic [0:35] conoOut;
    logic [0:35] dataoOut;
    logic        conoStrobe;
    logic        dataoStrobe;
    logic        dataiAck;

    ebus_responder_if bus();

    ebus_responder #(
        .DEV_NUM   (DEV),
        .RESP_DELAY(RD)
`ifdef EBUS_PI_VECTOR_EN
        ,
        .VECTOR    (VEC)
`endif
    ) dut (
        .clk        (clk),
        .CROBAR     (CROBAR),
        .ebus       (bus.slave),
        .coniIn     (coniIn),
        .dataiIn    (dataiIn),
        .devIntReq  (devIntReq),
        .conoOut    (conoOut),
        .dataoOut   (dataoOut),
        .conoStrobe (conoStrobe),
        .dataoStrobe(dataoStrobe),
        .dataiAck   (dataiAck)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pia_m  = 0;   // model of the PI level last written by CONO

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line n of [1:7] is bit (7-n) counting from the LSB.
    function automatic logic [1:7] pi_ref(input int pia, input logic req);
        if (!req || pia == 0) return 7'd0;
        return 7'(1 << (7 - pia));
    endfunction

    function automatic bit will_select(input logic [2:0] f, input logic [0:6] ds);
        if (f <= 3'd3) return ds == DEV;
`ifdef EBUS_PI_VECTOR_EN
        if (f == 3'd4) return devIntReq && (pia_m != 0) && ((int'(ds) % 8) == pia_m);
`endif
        return 1'b0;
    endfunction

    // Advance one clock; outputs sampled 1 ns after the edge. PI lines are
    // checked every cycle against the level/request seen before the edge.
    task automatic step();
        logic [1:7] exp_pi;
        bit in_rst;
        in_rst = CROBAR;
        exp_pi = in_rst ? 7'd0 : pi_ref(pia_m, devIntReq);
        @(posedge clk);
        #1;
        cyc++;
        if (in_rst) pia_m = 0;
        check_val("pi_lines", bus.ebusPI, exp_pi);
    endtask

    task automatic check_quiet(input string tag);
        check_val(tag, {bus.ebusXfer, bus.ebusDriving, conoStrobe, dataoStrobe, dataiAck}, 5'd0);
        check_val({tag, "_data"}, bus.ebusDataOut, 36'd0);
    endtask

    // mode 0: normal cycle; 1: demand re-raised right after release;
    // 2: reset pulsed during the transfer phase.
    task automatic run_txn(input logic [2:0] f, input logic [0:6] ds, input logic [0:35] wdata,
                           input int hold, input int abort_at, input int mode);
        logic [0:32] coni_v;
        logic [0:35] datai_v;
        logic [0:35] exp_out;
        bit          sel;
        bit          seen;
        bit          exp_drv;
        int          n;

        coni_v  = 33'({$urandom(), $urandom()});
        datai_v = 36'({$urandom(), $urandom()});
        bus.ebusDataIn = wdata;
        coniIn  = coni_v;
        dataiIn = datai_v;
        sel = will_select(f, ds);

        bus.ebusDS     = ds;
        bus.ebusFunc   = f;
        bus.ebusDemand = 1'b1;
        step();

        if (!sel) begin
            check_quiet("unselected");
            repeat (19) begin
                step();
                check_quiet("unselected");
            end
            bus.ebusDemand = 1'b0;
            step();
            step();
            return;
        end

        // Select/function lines are don't-care once the device is selected.
        bus.ebusDS   = 7'($urandom());
        bus.ebusFunc = 3'($urandom());

        if (abort_at >= 0) begin
            check_quiet("wait");
            repeat (abort_at) begin
                step();
                check_quiet("wait");
            end
            bus.ebusDemand = 1'b0;
            repeat (6) begin
                step();
                check_quiet("aborted");
            end
            return;
        end

        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (bus.ebusXfer === 1'b1) seen = 1'b1;
            else check_quiet("wait");
        end
        check_val("xfer_latency", n, RD + 1);
        if (!seen) begin
            bus.ebusDemand = 1'b0;
            repeat (3) step();
            return;
        end

        exp_drv = (f == 3'd1) || (f == 3'd3) || (f == 3'd4);
        case (f)
            3'd1:    exp_out = 36'(coni_v) * 36'd8 + 36'(pia_m);
            3'd3:    exp_out = datai_v;
`ifdef EBUS_PI_VECTOR_EN
            3'd4:    exp_out = VEC;
`endif
            default: exp_out = '0;
        endcase

        check_val("cono_strobe", conoStrobe, f == 3'd0);
        check_val("datao_strobe", dataoStrobe, f == 3'd2);
        check_val("datai_ack", dataiAck, f == 3'd3);
        check_val("driving", bus.ebusDriving, exp_drv);
        check_val("data_out", bus.ebusDataOut, exp_out);
        if (f == 3'd0) check_val("cono_out", conoOut, wdata);
        if (f == 3'd2) check_val("datao_out", dataoOut, wdata);
        if (f == 3'd0) pia_m = int'(wdata % 36'd8);

        // Device read sources move; the bus must keep the entry snapshot.
        coniIn  = 33'({$urandom(), $urandom()});
        dataiIn = 36'({$urandom(), $urandom()});

        if (mode == 2) begin
            step();
            check_val("pre_rst_xfer", bus.ebusXfer, 1'b1);
            CROBAR = 1'b1;
            step();
            CROBAR = 1'b0;
            check_quiet("after_reset");
            check_val("rst_cono_out", conoOut, 36'd0);
            check_val("rst_datao_out", dataoOut, 36'd0);
            repeat (5) begin
                step();
                check_quiet("rst_demand_held");
            end
            bus.ebusDemand = 1'b0;
            step();
            step();
            return;
        end

        repeat (hold) begin
            step();
            check_val("hold_xfer", bus.ebusXfer, 1'b1);
            check_val("hold_driving", bus.ebusDriving, exp_drv);
            check_val("hold_data", bus.ebusDataOut, exp_out);
            check_val("hold_pulses", {conoStrobe, dataoStrobe, dataiAck}, 3'd0);
        end

        bus.ebusDemand = 1'b0;
        step();
        check_quiet("release");

        if (mode == 1) begin
            bus.ebusDS     = DEV;
            bus.ebusFunc   = 3'd0;
            bus.ebusDemand = 1'b1;
            repeat (6) begin
                step();
                check_quiet("held_demand");
            end
            bus.ebusDemand = 1'b0;
            step();
        end else begin
            step();
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        CROBAR         = 1'b1;
        bus.ebusDS     = '0;
        bus.ebusFunc   = '0;
        bus.ebusDemand = 1'b0;
        bus.ebusDataIn = '0;
        coniIn         = '0;
        dataiIn        = '0;
        devIntReq      = 1'b0;
        step();
        step();
        check_val("rst_xfer", bus.ebusXfer, 1'b0);
        check_val("rst_driving", bus.ebusDriving, 1'b0);
        check_val("rst_data_out", bus.ebusDataOut, 36'd0);
        check_val("rst_pulses", {conoStrobe, dataoStrobe, dataiAck}, 3'd0);
        check_val("rst_cono", conoOut, 36'd0);
        check_val("rst_datao", dataoOut, 36'd0);
        CROBAR = 1'b0;
        step();

        // CONO writing PI level 5 with an interrupt pending.
        devIntReq = 1'b1;
        run_txn(3'd0, DEV, 36'o000000_000005, 2, -1, 0);
        check_val("pi_level5", bus.ebusPI, 7'b0000100);

        // DATAI with source changing during the transfer, then CONI.
        run_txn(3'd3, DEV, 36'({$urandom(), $urandom()}), 3, -1, 0);
        run_txn(3'd1, DEV, 36'({$urandom(), $urandom()}), 2, -1, 0);

        // Wrong device code.
        run_txn(3'd0, 7'o41, 36'({$urandom(), $urandom()}), 2, -1, 0);

        // Demand withdrawn while waiting.
        run_txn(3'd2, DEV, 36'({$urandom(), $urandom()}), 2, 1, 0);

        // Demand held straight through release, then a fresh CONO to level 3.
        run_txn(3'd2, DEV, 36'({$urandom(), $urandom()}), 1, -1, 1);
        run_txn(3'd0, DEV, 36'o000000_000003, 1, -1, 0);

        // PI-serve on level 3 (answered only when the vector feature is built).
        run_txn(3'd4, 7'b1010_011, 36'd0, 2, -1, 0);

        // Reset during a CONI transfer.
        run_txn(3'd1, DEV, 36'({$urandom(), $urandom()}), 2, -1, 2);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] f;
            logic [0:6] ds;
            int         ab;
            devIntReq = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f = 3'($urandom_range(0, 4));
            ds = ($urandom_range(0, 3) != 0) ? DEV : 7'($urandom());
            if (f == 3'd4 && $urandom_range(0, 1) == 1) ds = 7'(($urandom_range(0, 15) * 8) + pia_m);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, RD)) : -1;
            run_txn(f, ds, 36'({$urandom(), $urandom()}), int'($urandom_range(1, 4)), ab,
                    ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebus_responder.md
EBUS_RESPONDER -- requirements
Module: ebus_responder

Interface
REQ-001 Parameter DEV_NUM, default 7'o40, EBUS device-select code this responder answers.
REQ-002 Parameter RESP_DELAY, default 2, cycles from qualified demand to ebusXfer assertion (range 0..15).
REQ-003 Port clk  in  1  single clock, all state updates on its rising edge.
REQ-004 Port CROBAR  in  1  reset, synchronous, active-high.
REQ-005 Port ebusDS  in  7  EBUS device select [0:6].
REQ-006 Port ebusFunc  in  3  EBUS function: 0 CONO, 1 CONI, 2 DATAO, 3 DATAI, 4 PI-serve.
REQ-007 Port ebusDemand  in  1  EBOX demand, four-phase handshake request.
REQ-008 Port ebusDataIn  in  36  muxed EBUS data [0:35].
REQ-009 Port ebusXfer  out  1  responder transfer acknowledge.
REQ-010 Port ebusDriving  out  1  EBUSdriver.driving; requests the EBUS mux.
REQ-011 Port ebusDataOut  out  36  EBUSdriver.data; zero whenever ebusDriving=0.
REQ-012 Port ebusPI  out  7  PI request lines [1:7].
REQ-013 Port coniIn  in  33  device status [0:32] returned by CONI.
REQ-014 Port dataiIn  in  36  device data returned by DATAI.
REQ-015 Port devIntReq  in  1  device interrupt request level.
REQ-016 Ports conoOut/dataoOut  out  36 each  latched write data; conoStrobe/dataoStrobe/dataiAck  out  1 each  single-cycle pulses.

Function
REQ-017 Selection: in IDLE, armed, ebusDemand=1 and ebusDS=DEV_NUM and ebusFunc legal -> latch func, load counter with RESP_DELAY, enter WAIT.
REQ-018 States: IDLE, WAIT, XFER, REL; illegal func or non-matching ds leaves IDLE unchanged, no response.
REQ-019 WAIT: counter decrements each cycle; at zero -> XFER; ebusXfer first high exactly RESP_DELAY+1 cycles after the selecting edge.
REQ-020 WAIT with ebusDemand=0 -> IDLE (abort): no strobe, no xfer, no driving.
REQ-021 XFER entry, CONO: conoOut<=ebusDataIn, conoStrobe pulses 1 cycle, PIA<=ebusDataIn[33:35].
REQ-022 XFER entry, DATAO: dataoOut<=ebusDataIn, dataoStrobe pulses 1 cycle.
REQ-023 XFER entry, CONI: snapshot {coniIn, PIA} into ebusDataOut; DATAI: snapshot dataiIn, dataiAck pulses 1 cycle; ebusDriving=1 for all of XFER.
REQ-024 Snapshot held constant throughout XFER regardless of coniIn/dataiIn changes.
REQ-025 XFER: ebusXfer=1 until ebusDemand sampled 0 -> REL; REL: ebusXfer=0, ebusDriving=0, ebusDataOut=0, -> IDLE next cycle.
REQ-026 Arming: after REL or abort, no new selection until ebusDemand sampled 0 for at least one cycle in IDLE.
REQ-027 ebusDS/ebusFunc changes after selection ignored until IDLE.
REQ-028 PI: ebusPI[PIA] registered = devIntReq && PIA!=0; all other bits 0; PIA=0 -> ebusPI=0.
REQ-029 CONO changing PIA while devIntReq=1: old line drops and new line rises on the same edge, one cycle after conoStrobe.

Reset
REQ-030 CROBAR=1 at an edge: state IDLE, armed=0, PIA=0, counter 0, all outputs 0 next cycle, including mid-transaction (xfer/driving drop immediately).
REQ-031 Reset dominates simultaneous demand; arming then follows REQ-026.

Configuration
REQ-032 Macro EBUS_PI_VECTOR_EN defined: parameter VECTOR (36 bits, default 36'o0) present; func 4 selects when devIntReq=1, PIA!=0, ebusDS[4:6]=PIA (ebusDS[0:3] ignored); XFER drives VECTOR.
REQ-033 Macro undefined: func 4 is illegal per REQ-018; VECTOR absent; no response.

Verification
REQ-034 RESP_DELAY=2, CONO ds=7'o40 data=36'o000000_000005 -> ebusXfer high 3 cycles after select, conoStrobe 1 cycle, PIA=5, devIntReq=1 -> ebusPI=7'b0000100.
REQ-035 DATAI, dataiIn changed mid-XFER -> ebusDataOut holds entry snapshot, ebusDriving=1 until 1 cycle after demand low, then ebusDataOut=0.
REQ-036 ds=7'o41 with demand -> no xfer, no driving, no strobes for 20 cycles.
REQ-037 Demand dropped in WAIT -> IDLE, no strobe; held demand after REL -> no reselect until demand low one cycle.
REQ-038 CROBAR pulsed during XFER -> ebusXfer=ebusDriving=ebusPI=0 next cycle, PIA=0.
REQ-039 EBUS_PI_VECTOR_EN, VECTOR=36'o123, PIA=3, func 4, ebusDS[4:6]=3 -> ebusDataOut=36'o123; without macro -> no response.
